// File: rtl/usart_clkgen.sv
// Baud-rate prescaler and XCK clock controller for one USART channel.
// Produces TX/RX step enables for async, sync-master and sync-slave modes.
module usart_clkgen #(
  parameter int unsigned UBRR_W = 12
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic [UBRR_W-1:0] ubrr,
  input  logic              ubrr_wr,
  input  logic              u2x,
  input  logic              umsel,
  input  logic              ucpol,
  input  logic              ddr_xck,
  input  logic              xck_in,
  output logic              xck_out,
  output logic              xck_oe,
  output logic              tx_tick,
  output logic              rx_tick
);

  logic [UBRR_W-1:0] cnt_q, cnt_d;
  logic [3:0]        div_q, div_d;
  logic              xck_int_q, xck_int_d;
  logic              xck_prev_q, xck_prev_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              hist_q, hist_d;
  logic              tx_q, tx_d;
  logic              rx_q, rx_d;
  logic              umsel_q, ddr_q, u2x_q;

  logic p, mode_chg, master, slave, slave_lvl, div_match, out_en;

  always_comb begin
    mode_chg  = (umsel != umsel_q) | (ddr_xck != ddr_q) | (u2x != u2x_q);
    master    = umsel & ddr_xck;
    slave     = umsel & ~ddr_xck;
    // A divisor write takes priority over the natural reload tick.
    p         = (cnt_q == '0) & ~ubrr_wr;
    slave_lvl = sync2_q ^ ucpol;
    div_match = u2x ? (div_q[2:0] == 3'd7) : (div_q == 4'd15);
    out_en    = ~ireset & ~mode_chg;

    if (ubrr_wr || (cnt_q == '0)) cnt_d = ubrr;
    else                          cnt_d = cnt_q - UBRR_W'(1);

    div_d = div_q;
    if (mode_chg)        div_d = 4'd0;
    else if (p && !umsel) div_d = div_q + 4'd1;

    xck_int_d = xck_int_q;
    if (mode_chg || !master) xck_int_d = 1'b0;
    else if (p)              xck_int_d = ~xck_int_q;

    xck_prev_d = mode_chg ? 1'b0 : xck_int_q;

    sync1_d = xck_in;
    sync2_d = sync1_q;
    // History tracks the current level so a mode change never fakes an edge.
    hist_d  = slave_lvl;

    tx_d = 1'b0;
    rx_d = 1'b0;
    if (!mode_chg) begin
      if (master) begin
        tx_d = xck_int_q & ~xck_prev_q;
        rx_d = ~xck_int_q & xck_prev_q;
      end else if (slave) begin
        tx_d = slave_lvl & ~hist_q;
        rx_d = ~slave_lvl & hist_q;
      end
    end

    tx_tick = out_en & (umsel ? tx_q : (p & div_match));
    rx_tick = out_en & (umsel ? rx_q : p);
    xck_out = ~ireset & master & (xck_int_q ^ ucpol);
    xck_oe  = ~ireset & master;
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      cnt_q      <= '0;
      div_q      <= 4'd0;
      xck_int_q  <= 1'b0;
      xck_prev_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      tx_q       <= 1'b0;
      rx_q       <= 1'b0;
      umsel_q    <= 1'b0;
      ddr_q      <= 1'b0;
      u2x_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      xck_int_q  <= xck_int_d;
      xck_prev_q <= xck_prev_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      umsel_q    <= umsel;
      ddr_q      <= ddr_xck;
      u2x_q      <= u2x;
    end
  end

endmodule

// File: doc/usart_clkgen.md
# usart_clkgen

Baud-rate and XCK clock controller for one USARTn channel of the ATmega328PB core. It divides `cp2` by the programmed UBRR value and produces the one-cycle enables that step the USART transmitter and receiver. In synchronous mode it either drives the XCKn pin as master or follows an external XCKn as slave. It sits between the USART register file (UBRRn, UCSRnA/C bits, DDR_XCKn) and the USART TX/RX datapaths.

## Interface
- `UBRR_W`, default 12: width of the baud divisor (UBRRnH[3:0]:UBRRnL).
- `cp2` in 1: system clock; all state changes on its rising edge.
- `ireset` in 1: asynchronous, active-high reset.
- `ubrr` in UBRR_W: baud divisor.
- `ubrr_wr` in 1: one-cycle strobe on a UBRRnL write; forces a divisor reload.
- `u2x` in 1: double-speed select, async mode only.
- `umsel` in 1: 0 selects async, 1 selects sync.
- `ucpol` in 1: XCK polarity, sync mode only.
- `ddr_xck` in 1: DDR_XCKn bit; 1 selects sync master, 0 selects sync slave.
- `xck_in` in 1: XCKn pin input, asynchronous to `cp2`.
- `xck_out` out 1: XCKn pin output value.
- `xck_oe` out 1: XCKn output enable; equals `umsel & ddr_xck`.
- `tx_tick` out 1: one-cycle enable that shifts or launches the next TX bit.
- `rx_tick` out 1: one-cycle enable for RX sampling.

## Operation
- Prescaler `cnt` (UBRR_W bits) counts down. When `cnt==0` it generates prescaler tick `p` and reloads `ubrr`; otherwise it decrements. A `ubrr_wr` pulse loads `ubrr` into `cnt` immediately, suppresses `p` in that cycle, and overrides the reload.
- `p` has period `ubrr+1` cycles. With `ubrr==0`, `p` is high every cycle.
- Async mode (`umsel=0`):
  - `rx_tick = p`, giving 16× oversampling (8× when `u2x=1`).
  - A 4-bit `div` counter increments on each `p`. `tx_tick = p & (div==15)`; when `u2x=1`, `tx_tick = p & (div[2:0]==7)`.
  - `xck_out=0`, `xck_oe=0`.
- Sync master (`umsel=1`, `ddr_xck=1`):
  - Internal `xck_int` toggles on each `p`, so the XCK period is `2(ubrr+1)` cycles.
  - `xck_out = xck_int ^ ucpol`.
  - `tx_tick` is asserted in the cycle after `xck_int` rises; `rx_tick` in the cycle after it falls.
  - `u2x` is ignored.
- Sync slave (`umsel=1`, `ddr_xck=0`):
  - `xck_in` passes through a two-flop synchronizer and then a history flop.
  - A rising edge of `xck_in ^ ucpol` produces `tx_tick`; a falling edge produces `rx_tick`.
  - The prescaler keeps running but its output is unused. `xck_out=0`.
  - An external XCK must be slower than `cp2`/4; faster edges are not guaranteed to be detected.
- Mode change: any change of `umsel`, `ddr_xck` or `u2x`, detected against registered copies, clears `div`, `xck_int` and the edge history, and suppresses both ticks for that cycle. `cnt` is not affected.
- `tx_tick` and `rx_tick` are never high in the same cycle in sync modes. In async mode both may be high together.

## Timing
- Reset values: `cnt=0`, `div=0`, `xck_int=0`, synchronizer flops 0, `tx_tick=0`, `rx_tick=0`, `xck_out=0`, `xck_oe=0`.
- Reset asserted mid-operation clears all state immediately, with no wait for a clock edge. The first `p` occurs in the first cycle after release, because `cnt==0`.
- `rx_tick`, `tx_tick` and `p` are combinational decodes of registered state plus `ubrr_wr`. Sync-master ticks are registered, one cycle after the `xck_int` transition.
- Sync-slave latency: 3 `cp2` cycles from an `xck_in` transition to the corresponding tick.
- `ubrr_wr` with simultaneous `cnt==0`: the write wins, `cnt` loads the new value, and no `p` is generated.
- `div` wraps 15→0 and never saturates.
- `xck_oe` is combinational from its inputs.

## Test plan
- Async, `ubrr=3`, `u2x=0`, after reset → `rx_tick` every 4 cycles starting in cycle 1; `tx_tick` every 64 cycles, coincident with every 16th `rx_tick`.
- Async, `ubrr=3`, `u2x=1` → `tx_tick` period 32 cycles. Toggling `u2x` mid-stream → both ticks suppressed for 1 cycle and `div` restarts at 0.
- Sync master, `ubrr=1`, `ucpol=0` → `xck_out` period 4 cycles (2 high, 2 low), `xck_oe=1`; `tx_tick` 1 cycle after each rise, `rx_tick` 1 cycle after each fall. With `ucpol=1` → `xck_out` inverted, tick timing relative to `xck_int` unchanged.
- Sync slave, `xck_in` square wave with 10-cycle period → `tx_tick` exactly 3 cycles after each rising edge, `rx_tick` 3 cycles after each falling edge, `xck_oe=0`.
- `ubrr=100` running; pulse `ubrr_wr` with `ubrr=2` while `cnt=57` → next `p` 3 cycles after the write, then every 3 cycles. Repeat with the write landing exactly on `cnt==0` → no `p` in the write cycle.
- Assert `ireset` asynchronously mid-count in sync master with `xck_out=1` → `xck_out`, `tx_tick` and `rx_tick` drop to 0 before the next `cp2` edge; after release, `p` occurs in the first cycle.
